div_core_radix: RTL

- Parametrised iterative integer divider; successor to the fixed radix-4 unsigned divider core.
- Adds:
  - configurable bits-per-cycle;
  - signed/unsigned mode with sign correction;
  - RISC-V divide-by-zero and signed-overflow results;
  - internal CLZ-based early start;
  - ready/start/done handshake;
  - abort.
- Sits inside the div execution unit, behind the issue interface.

---
 rtl/div_core_radix.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/div_core_radix.sv
// Iterative integer divider with configurable radix (1, 2 or 4 quotient bits
// per cycle). It handles signed and unsigned operands and returns the RISC-V
// results for divide-by-zero and signed overflow. A CLZ-based early start
// skips the leading quotient bits that must be zero.
module div_core_radix #(
  parameter int DIV_WIDTH      = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  input  logic                 is_signed,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 abort,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  // The divisor register is wider than the operands. The per-step shifts in
  // the first RUN cycle can push the divisor above DIV_WIDTH bits.
  localparam int XW = DIV_WIDTH + BITS_PER_CYCLE;
  // Signed width for CLZ values (0..DIV_WIDTH) and for their difference.
  localparam int CW = $clog2(DIV_WIDTH) + 2;
  localparam int NW = $clog2(DIV_WIDTH);
  localparam int LB = $clog2(BITS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                 state_reg, state_next;
  logic [DIV_WIDTH-1:0]   q_reg;
  logic [DIV_WIDTH-1:0]   r_reg;
  logic [XW-1:0]          d_reg;
  logic [NW-1:0]          cnt_reg;
  logic                   neg_q_reg;
  logic                   neg_r_reg;
  logic                   dbz_reg;
  logic                   done_reg;
  logic [DIV_WIDTH-1:0]   quotient_reg;
  logic [DIV_WIDTH-1:0]   remainder_reg;
  logic                   div_by_zero_reg;

  // Count leading zeros; an all-zero value yields DIV_WIDTH.
  function automatic logic [CW-1:0] clz(input logic [DIV_WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = CW'(DIV_WIDTH);
    found = 1'b0;
    for (int i = DIV_WIDTH - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = CW'(DIV_WIDTH - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Operand decode for the accept cycle.
  logic                 sign_a, sign_b;
  logic [DIV_WIDTH-1:0] mag_a, mag_b;
  logic [CW-1:0]        clz_a, clz_b, delta_u, shift_amt;
  logic signed [CW-1:0] delta;
  logic                 fast_dbz, fast_ovf, fast_small, fast_any;
  logic [NW-1:0]        cnt_init;
  logic [XW-1:0]        div_init;

  assign sign_a = is_signed & dividend[DIV_WIDTH-1];
  assign sign_b = is_signed & divisor[DIV_WIDTH-1];
  assign mag_a  = sign_a ? -dividend : dividend;
  assign mag_b  = sign_b ? -divisor : divisor;
  assign clz_a  = clz(mag_a);
  assign clz_b  = clz(mag_b);
  assign delta  = $signed(clz_b) - $signed(clz_a);
  assign delta_u = delta;

  assign fast_dbz   = (divisor == '0);
  assign fast_ovf   = is_signed && (dividend == {1'b1, {(DIV_WIDTH-1){1'b0}}}) &&
                      (divisor == '1);
  assign fast_small = delta[CW-1];
  assign fast_any   = fast_dbz | fast_ovf | fast_small;

  // N-1 = floor(delta / B), and the initial shift is (N-1)*B. B is a power
  // of two, so both values come from shifting and masking delta.
  assign cnt_init  = NW'(delta_u >> LB);
  assign shift_amt = delta_u & ~CW'(BITS_PER_CYCLE - 1);
  assign div_init  = XW'(mag_b) << shift_amt;

  // One RUN cycle: BITS_PER_CYCLE chained restoring steps, MSB first.
  logic [DIV_WIDTH-1:0]      rem_chain [0:BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] qbits;

  assign rem_chain[0] = r_reg;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [XW-1:0]      cand;
    logic               cand_hi;
    logic [DIV_WIDTH:0] diff;
    logic               borrow;
    assign cand    = d_reg << (BITS_PER_CYCLE - 1 - gi);
    // Any divisor bit at or above DIV_WIDTH means the divisor is larger
    // than the remainder, so the step cannot subtract.
    assign cand_hi = |cand[XW-1:DIV_WIDTH];
    assign diff    = {1'b0, rem_chain[gi]} - {1'b0, cand[DIV_WIDTH-1:0]};
    assign borrow  = cand_hi | diff[DIV_WIDTH];
    assign qbits[BITS_PER_CYCLE-1-gi] = ~borrow;
    assign rem_chain[gi+1] = borrow ? rem_chain[gi] : diff[DIV_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. Abort wins over every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start && !abort) state_next = fast_any ? FIX : RUN;
      RUN: begin
        if (abort)              state_next = IDLE;
        else if (cnt_reg == '0) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg           <= '0;
      r_reg           <= '0;
      d_reg           <= '0;
      cnt_reg         <= '0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      dbz_reg         <= 1'b0;
      done_reg        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            d_reg     <= div_init;
            cnt_reg   <= cnt_init;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            dbz_reg   <= 1'b0;
            if (fast_dbz) begin
              q_reg   <= '1;
              r_reg   <= dividend;
              dbz_reg <= 1'b1;
            end else if (fast_ovf) begin
              q_reg <= dividend;
              r_reg <= '0;
            end else if (fast_small) begin
              q_reg <= '0;
              r_reg <= dividend;
            end else begin
              q_reg     <= '0;
              r_reg     <= mag_a;
              neg_q_reg <= sign_a ^ sign_b;
              neg_r_reg <= sign_a;
            end
          end
        end
        RUN: begin
          if (!abort) begin
            q_reg   <= {q_reg[DIV_WIDTH-BITS_PER_CYCLE-1:0], qbits};
            r_reg   <= rem_chain[BITS_PER_CYCLE];
            d_reg   <= d_reg >> BITS_PER_CYCLE;
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        FIX: begin
          if (!abort) begin
            quotient_reg    <= neg_q_reg ? -q_reg : q_reg;
            remainder_reg   <= neg_r_reg ? -r_reg : r_reg;
            div_by_zero_reg <= dbz_reg;
            done_reg        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready       = (state_reg == IDLE);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule
